// File: rtl/cve2v_obi_mem_responder.sv
// OBI memory endpoint: grants under an outstanding limit, byte-enabled word memory,
// in-order fixed-latency responses with error flag for unmapped addresses.
module cve2v_obi_mem_responder #(
    parameter int unsigned MemBytes       = 65536,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i,
    output logic [2:0]  outstanding_o
);

    localparam int unsigned AddrBits = $clog2(MemBytes);
    localparam int unsigned Words    = MemBytes / 4;
    localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);

    logic [31:0]            mem [Words];
    logic [2:0]             outstanding_q;
    logic [RespLatency-1:0] pipe_valid_q;
    logic [RespLatency-1:0] pipe_err_q;
    logic [31:0]            pipe_rdata_q [RespLatency];

    logic                   accept;
    logic                   in_range;
    logic                   slot_free;
    logic [AddrBits-3:0]    word_idx;
    logic [31:0]            rsp_rdata;
    logic                   unused_addr_lsb;

    // Base is MemBytes-aligned, so the range check reduces to an upper-bit match
    assign in_range  = (addr_i[31:AddrBits] == BaseAddr[31:AddrBits]);
    assign word_idx  = addr_i[AddrBits-1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    assign slot_free = (outstanding_q < MaxOut) | rvalid_o;
    assign gnt_o     = rst_ni & req_i & ~stall_i & slot_free;
    assign accept    = req_i & gnt_o;

    assign rsp_rdata = (accept & ~we_i & in_range) ? mem[word_idx] : 32'h0;

    assign rvalid_o      = pipe_valid_q[RespLatency-1];
    assign err_o         = pipe_err_q[RespLatency-1];
    assign rdata_o       = pipe_rdata_q[RespLatency-1];
    assign outstanding_o = outstanding_q;

    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Data and error are zeroed with the valid bit so idle outputs read as 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                pipe_rdata_q[i] <= 32'h0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_err_q[0]   <= accept & ~in_range;
            pipe_rdata_q[0] <= rsp_rdata;
            for (int i = 1; i < RespLatency; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_rdata_q[i] <= pipe_rdata_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= 3'd0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cve2v_obi_mem_responder.sv
// Bench for cve2v_obi_mem_responder: instance A (latency 3) is scoreboarded every cycle,
// instance B (latency 4) exercises reset while a read is in flight.
module tb_cve2v_obi_mem_responder;

    localparam int LatA = 3;
    localparam int LatB = 4;
    localparam int MaxA = 2;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_a_n = 1'b0, rst_b_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0, stall = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic [2:0]  out_a, out_b;

    int n_chk = 0;
    int n_fail = 0;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mdl [int];
    logic [31:0] cur;
    logic [31:0] last_rsp;
    logic        exp_rv, exp_gnt, in_rng;
    int          widx;
    int          sample_n = 0;
    int          exp_out = 0;
    int          peak_out = 0;

    cve2v_obi_mem_responder #(.MemBytes(65536), .BaseAddr(32'h0), .RespLatency(LatA), .MaxOutstanding(MaxA)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_a_n), .req_i(req_a), .gnt_o(gnt_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
        .stall_i(stall), .outstanding_o(out_a)
    );

    cve2v_obi_mem_responder #(.MemBytes(65536), .BaseAddr(32'h0), .RespLatency(LatB), .MaxOutstanding(2)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_b_n), .req_i(req_b), .gnt_o(gnt_b), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
        .stall_i(1'b0), .outstanding_o(out_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard for instance A, sampled on the falling edge
    always @(negedge clk_i) begin
        if (!rst_a_n) begin
            q.delete();
            exp_out = 0;
        end else begin
            exp_rv = (q.size() > 0) && (q[0].due == sample_n);
            chk("outstanding", 32'(out_a), 32'(exp_out));
            chk("rvalid", 32'(rvalid_a), 32'(exp_rv));
            if (exp_rv) begin
                e = q.pop_front();
                chk("rdata", rdata_a, e.data);
                chk("err", 32'(err_a), 32'(e.err));
                last_rsp = rdata_a;
            end else begin
                chk("idle_rdata_err", {rdata_a[30:0], err_a}, 32'h0);
            end
            exp_gnt = req_a && !stall && ((exp_out < MaxA) || exp_rv);
            chk("gnt", 32'(gnt_a), 32'(exp_gnt));
            if (int'(out_a) > peak_out) peak_out = int'(out_a);
            if (req_a && exp_gnt) begin
                in_rng = (addr < 32'h0001_0000);
                widx   = int'(addr[15:2]);
                e.due  = sample_n + LatA;
                e.err  = !in_rng;
                e.data = 32'h0;
                if (we) begin
                    if (in_rng) begin
                        cur = mdl.exists(widx) ? mdl[widx] : 32'hx;
                        for (int i = 0; i < 4; i++)
                            if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
                        mdl[widx] = cur;
                    end
                end else if (in_rng) begin
                    e.data = mdl.exists(widx) ? mdl[widx] : 32'hx;
                end
                q.push_back(e);
                exp_out++;
            end
            if (exp_rv) exp_out--;
        end
        sample_n++;
    end

    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req_a = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(negedge clk_i);
        while (!gnt_a && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("gnt_timeout", 32'(n < 20), 32'h1);
        @(posedge clk_i); #1;
        req_a = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_a = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_gnt", 32'(gnt_a), 32'h0);
        chk("rst_rvalid", 32'(rvalid_a), 32'h0);
        chk("rst_rdata", rdata_a, 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_out", 32'(out_a), 32'h0);
        chk("rst_b_out", 32'(out_b), 32'h0);
        @(posedge clk_i); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1; req_a = 1'b0;
        idle(2);

        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 4'hF, 32'h10, 32'h0);
        idle(6);
        chk("full_write_read", last_rsp, 32'hDEADBEEF);

        issue(1'b1, 4'b0101, 32'h10, 32'h11223344);
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        idle(6);
        chk("partial_write_read", last_rsp, 32'hDE22BE44);

        issue(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
        issue(1'b0, 4'hF, 32'h12, 32'h0);
        idle(6);
        chk("be0_noop", last_rsp, 32'hDE22BE44);

        issue(1'b1, 4'hF, 32'h0, 32'hA5A50F0F);
        issue(1'b0, 4'hF, 32'h0001_0000, 32'h0);
        issue(1'b1, 4'hF, 32'h0001_0000, 32'hFFFFFFFF);
        issue(1'b0, 4'hF, 32'h0, 32'h0);
        idle(6);
        chk("oor_write_no_effect", last_rsp, 32'hA5A50F0F);
        issue(1'b1, 4'hF, 32'hFFFC, 32'h0BADF00D);
        issue(1'b0, 4'hF, 32'hFFFF, 32'h0);
        idle(6);
        chk("top_word", last_rsp, 32'h0BADF00D);

        peak_out = 0;
        issue(1'b0, 4'hF, 32'h10, 32'h0);
        issue(1'b0, 4'hF, 32'h0, 32'h0);
        issue(1'b0, 4'hF, 32'hFFFC, 32'h0);
        issue(1'b0, 4'hF, 32'h14, 32'h0);
        idle(6);
        chk("peak_out", 32'(peak_out), 32'h2);

        stall = 1'b1; req_a = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0;
        repeat (5) begin
            @(negedge clk_i);
            chk("stall_gnt", 32'(gnt_a), 32'h0);
        end
        @(posedge clk_i); #1;
        stall = 1'b0;
        @(negedge clk_i);
        chk("stall_release_gnt", 32'(gnt_a), 32'h1);
        @(posedge clk_i); #1;
        req_a = 1'b0;
        idle(6);
        chk("stall_read", last_rsp, 32'hA5A50F0F);

        req_b = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk_i);
        chk("b_wr_gnt", 32'(gnt_b), 32'h1);
        @(posedge clk_i); #1;
        req_b = 1'b0;
        repeat (LatB - 1) begin
            @(negedge clk_i);
            chk("b_wr_early", 32'(rvalid_b), 32'h0);
        end
        @(negedge clk_i);
        chk("b_wr_rvalid", 32'(rvalid_b), 32'h1);
        chk("b_wr_err", 32'(err_b), 32'h0);
        @(posedge clk_i); #1;

        req_b = 1'b1; we = 1'b0;
        @(negedge clk_i);
        chk("b_rd_gnt", 32'(gnt_b), 32'h1);
        @(posedge clk_i); #1;
        req_b = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_b_n = 1'b0; req_b = 1'b1;
        @(negedge clk_i);
        chk("b_rst_gnt", 32'(gnt_b), 32'h0);
        chk("b_rst_out", 32'(out_b), 32'h0);
        chk("b_rst_rvalid", 32'(rvalid_b), 32'h0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_b_n = 1'b1; req_b = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            chk("b_dropped_rvalid", 32'(rvalid_b), 32'h0);
        end
        @(posedge clk_i); #1;
        req_b = 1'b1;
        @(negedge clk_i);
        chk("b_post_rst_gnt", 32'(gnt_b), 32'h1);
        @(posedge clk_i); #1;
        req_b = 1'b0;
        repeat (LatB - 1) begin
            @(negedge clk_i);
            chk("b_rd_early", 32'(rvalid_b), 32'h0);
        end
        @(negedge clk_i);
        chk("b_rd_rvalid", 32'(rvalid_b), 32'h1);
        chk("b_rd_rdata", rdata_b, 32'h12345678);
        chk("b_rd_out", 32'(out_b), 32'h1);
        @(negedge clk_i);
        chk("b_final_out", 32'(out_b), 32'h0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
